// File: rtl/lm80c_ps2_keyboard_if.sv
// PS/2 pin pair and key-matrix/status bundle between the board pins and the LM80C core.
interface lm80c_ps2_keyboard_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [63:0] km;
  logic [7:0]  code;
  logic        code_valid;
  logic        frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  km, code, code_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output km, code, code_valid, frame_err
  );
endinterface

// File: rtl/lm80c_ps2_keyboard.sv
// PS/2 set-2 keyboard receiver and decoder driving the LM80C 8x8 active-low key matrix.
// Bytes go through sync/filter, an 11-bit frame FSM, prefix tracking and a mapping ROM.
module lm80c_ps2_keyboard #(
  parameter int unsigned CLK_HZ     = 42_000_000,
  parameter int unsigned FILTER     = 8,
  parameter int unsigned TIMEOUT_US = 200,
  parameter string       MAP_FILE   = "lm80c_kbmap.hex"
) (
  input  logic           sys_clock,
  input  logic           reset_n,
  lm80c_ps2_keyboard_if.slave kb
);

  localparam int unsigned FILT_W    = $clog2(FILTER + 1);
  localparam int unsigned TO_CYCLES = (CLK_HZ / 1_000_000) * TIMEOUT_US;
  localparam int unsigned TO_W      = $clog2(TO_CYCLES + 1);
  localparam bit          MAP_STOCK = (MAP_FILE == "lm80c_kbmap.hex");

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  // Mapping ROM contents {valid, row, col}; only the stock map is compiled in.
  function automatic logic [6:0] rom_entry(input logic [8:0] addr);
    rom_entry = '0;
    if (MAP_STOCK) begin
      case (addr)
        9'h012:  rom_entry = {1'b1, 3'd0, 3'd6};
        9'h059:  rom_entry = {1'b1, 3'd0, 3'd7};
        9'h05A:  rom_entry = {1'b1, 3'd1, 3'd0};
        9'h029:  rom_entry = {1'b1, 3'd1, 3'd1};
        9'h01C:  rom_entry = {1'b1, 3'd2, 3'd1};
        9'h015:  rom_entry = {1'b1, 3'd2, 3'd2};
        9'h16B:  rom_entry = {1'b1, 3'd7, 3'd0};
        9'h175:  rom_entry = {1'b1, 3'd7, 3'd3};
        9'h172:  rom_entry = {1'b1, 3'd7, 3'd4};
        9'h174:  rom_entry = {1'b1, 3'd7, 3'd6};
        default: rom_entry = '0;
      endcase
    end
  endfunction

  logic [1:0]        clk_sync_q, dat_sync_q;
  logic              filt_q, filt_d;
  logic [FILT_W-1:0] fcnt_q, fcnt_d;
  logic              tick;
  logic              clk_s, dat_s;

  rx_state_e         state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]        code_q, code_d;
  logic              code_valid_q, code_valid_d;
  logic              frame_err_q, frame_err_d;

  logic              ext_q, ext_d, brk_q, brk_d;
  logic [2:0]        skip_q, skip_d;
  logic [6:0]        rom_q;
  logic              look_q, look_d, look_brk_q, look_brk_d;
  logic [63:0]       km_q, km_d;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // Glitch filter: the clock follows the pin only after FILTER agreeing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    tick   = 1'b0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FILT_W'(FILTER - 1)) begin
        filt_d = clk_s;
        tick   = ~clk_s;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Frame receiver; a tick always takes priority over the gap timeout.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    to_cnt_d     = '0;
    if (state_q != RX_IDLE) to_cnt_d = to_cnt_q + 1'b1;
    if (tick) begin
      to_cnt_d = '0;
      case (state_q)
        RX_IDLE: begin
          if (!dat_s) begin
            state_d   = RX_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = dat_s;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          if (dat_s && (^{shift_q, par_q})) begin
            code_d       = shift_q;
            code_valid_d = 1'b1;
          end else begin
            frame_err_d  = 1'b1;
          end
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE && to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
      state_d     = RX_IDLE;
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
    end
  end

  // Set-2 decoder: prefix flags, pause-sequence skip, and matrix writes from the ROM.
  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    skip_d     = skip_q;
    look_d     = 1'b0;
    look_brk_d = look_brk_q;
    km_d       = km_q;
    if (look_q && rom_q[6]) km_d[rom_q[5:0]] = look_brk_q;
    if (code_valid_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (code_q)
          8'hE0: ext_d  = 1'b1;
          8'hF0: brk_d  = 1'b1;
          8'hE1: skip_d = 3'd7;
          8'hAA, 8'hFC, 8'h00, 8'hFF: begin
            km_d  = '1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
          default: begin
            look_d     = 1'b1;
            look_brk_d = brk_q;
            ext_d      = 1'b0;
            brk_d      = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q   <= 2'b11;
      dat_sync_q   <= 2'b11;
      filt_q       <= 1'b1;
      fcnt_q       <= '0;
      state_q      <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      skip_q       <= '0;
      rom_q        <= '0;
      look_q       <= 1'b0;
      look_brk_q   <= 1'b0;
      km_q         <= '1;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], kb.ps2_clk};
      dat_sync_q   <= {dat_sync_q[0], kb.ps2_data};
      filt_q       <= filt_d;
      fcnt_q       <= fcnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      skip_q       <= skip_d;
      rom_q        <= rom_entry({ext_q, code_q});
      look_q       <= look_d;
      look_brk_q   <= look_brk_d;
      km_q         <= km_d;
    end
  end

  assign kb.km         = km_q;
  assign kb.code       = code_q;
  assign kb.code_valid = code_valid_q;
  assign kb.frame_err  = frame_err_q;

endmodule
